// File: rtl/segway_math_pipe_if.sv
// segway_math_pipe_if: sample-in / speed-out bundle for the segway math pipeline
interface segway_math_pipe_if #(
  parameter int W    = 12,
  parameter int SS_W = 8
);
  logic                 vld_in;
  logic signed [W-1:0]  PID_cntrl;
  logic [SS_W-1:0]      ss_tmr;
  logic [W-1:0]         steer_pot;
  logic                 en_steer;
  logic                 pwr_up;
  logic                 vld_out;
  logic signed [W-1:0]  lft_spd;
  logic signed [W-1:0]  rght_spd;
  logic                 too_fast;
  modport master (
    output vld_in, PID_cntrl, ss_tmr, steer_pot, en_steer, pwr_up,
    input  vld_out, lft_spd, rght_spd, too_fast
  );
  modport slave (
    input  vld_in, PID_cntrl, ss_tmr, steer_pot, en_steer, pwr_up,
    output vld_out, lft_spd, rght_spd, too_fast
  );
endinterface

// File: rtl/segway_math_pipe.sv
// segway_math_pipe: soft-start, steering mix, deadzone shaping and slew-limited motor speed pipeline
module segway_math_pipe #(
  parameter int W          = 12,
  parameter int SS_W       = 8,
  parameter int MIN_DUTY   = 960,
  parameter int LOW_BAND   = 60,
  parameter int GAIN_SHIFT = 4,
  parameter int SLEW       = 64,
  parameter int FAST_THR   = 1792,
  parameter int FAST_CNT   = 4
) (
  input logic              clk,
  input logic              rst_n,
  segway_math_pipe_if.slave bus
);
  localparam int PW = W + SS_W + 1;
  localparam int SW = W + GAIN_SHIFT + 2;
  localparam int CW = $clog2(FAST_CNT + 1);
  localparam logic signed [W:0]   POT_LO  = (W+1)'(2 ** (W - 3));
  localparam logic signed [W:0]   POT_HI  = (W+1)'(7 * 2 ** (W - 3));
  localparam logic signed [W:0]   POT_MID = (W+1)'(2 ** (W - 1) - 1);
  localparam logic signed [W-1:0] S_MAX   = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] S_MIN   = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W-1:0] THR     = W'(FAST_THR);
  localparam logic [CW-1:0]       CNT_MAX = CW'(FAST_CNT);

  // Saturate a wide signed value into the W-bit output range.
  function automatic logic signed [W-1:0] sat(input logic signed [SW-1:0] v);
    return (v > SW'(S_MAX)) ? S_MAX : (v < SW'(S_MIN)) ? S_MIN : v[W-1:0];
  endfunction

  // Outside the low band add the minimum duty away from zero; inside it apply gain instead.
  function automatic logic signed [W-1:0] shape(input logic signed [W:0] t);
    logic signed [SW-1:0] e;
    e = SW'(t);
    return sat((e > SW'(LOW_BAND)) ? e + SW'(MIN_DUTY) :
               (e < -SW'(LOW_BAND)) ? e - SW'(MIN_DUTY) : e <<< GAIN_SHIFT);
  endfunction

  // Move from o toward t by at most SLEW; one extra bit keeps the window from wrapping.
  function automatic logic signed [W-1:0] slew(input logic signed [W-1:0] o, input logic signed [W-1:0] t);
    logic signed [W:0] lo, hi, tt;
    lo = (W+1)'(o) - (W+1)'(SLEW);
    hi = (W+1)'(o) + (W+1)'(SLEW);
    tt = (W+1)'(t);
    return sat(SW'((tt > hi) ? hi : (tt < lo) ? lo : tt));
  endfunction

  logic signed [PW-1:0] prod;
  logic signed [W-1:0]  pid_ss;
  logic signed [W:0]    pot, pot_c, st_x, steer, st_e, lt_d, rt_d;
  logic                 v1, v2, v3, pwr1, tf;
  logic signed [W:0]    lt1, rt1;
  logic signed [W-1:0]  tl2, tr2, lft, rght, nl, nr;
  logic [CW-1:0]        cnt, cnt_d;

  // Stage 1 datapath: soft-start scaling and clamped, scaled steering mix.
  always_comb begin
    prod   = PW'(bus.PID_cntrl) * PW'($signed({1'b0, bus.ss_tmr}));
    pid_ss = W'(prod >>> SS_W);
    pot    = $signed({1'b0, bus.steer_pot});
    pot_c  = (pot < POT_LO) ? POT_LO : (pot > POT_HI) ? POT_HI : pot;
    st_x   = pot_c - POT_MID;
    steer  = (st_x >>> 4) + (st_x >>> 3);
    st_e   = bus.en_steer ? steer : '0;
    lt_d   = (W+1)'(pid_ss) + st_e;
    rt_d   = (W+1)'(pid_ss) - st_e;
  end

  // Stage 1 registers: torques and pwr_up captured together per accepted sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      pwr1 <= 1'b0;
      lt1  <= '0;
      rt1  <= '0;
    end else begin
      v1 <= bus.vld_in;
      if (bus.vld_in) begin
        pwr1 <= bus.pwr_up;
        lt1  <= lt_d;
        rt1  <= rt_d;
      end
    end
  end

  // Stage 2 registers: deadzone-shaped targets, zeroed when power is off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2  <= 1'b0;
      tl2 <= '0;
      tr2 <= '0;
    end else begin
      v2 <= v1;
      if (v1) begin
        tl2 <= pwr1 ? shape(lt1) : '0;
        tr2 <= pwr1 ? shape(rt1) : '0;
      end
    end
  end

  // Stage 3 datapath: slew-limited next outputs and overspeed persistence count.
  always_comb begin
    nl    = slew(lft, tl2);
    nr    = slew(rght, tr2);
    cnt_d = (nl > THR || nr > THR) ? ((cnt == CNT_MAX) ? cnt : cnt + CW'(1)) : '0;
  end

  // Stage 3 registers: outputs, counter and flag advance only on updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3   <= 1'b0;
      lft  <= '0;
      rght <= '0;
      cnt  <= '0;
      tf   <= 1'b0;
    end else begin
      v3 <= v2;
      if (v2) begin
        lft  <= nl;
        rght <= nr;
        cnt  <= cnt_d;
        tf   <= (cnt_d == CNT_MAX);
      end
    end
  end

  assign bus.vld_out  = v3;
  assign bus.lft_spd  = lft;
  assign bus.rght_spd = rght;
  assign bus.too_fast = tf;
endmodule

// File: tb/tb_segway_math_pipe.sv
// tb_segway_math_pipe: directed vector table plus multi-cycle corner sequences for segway_math_pipe
module tb_segway_math_pipe;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  int   upd_cnt;

  segway_math_pipe_if #(.W(12), .SS_W(8)) bus ();

  segway_math_pipe dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [11:0] pid;
    logic [7:0]  ss;
    logic [11:0] pot;
    logic        en;
    logic        pwr;
    int          n;
    int          el;
    int          er;
    int          tf;
  } vec_t;

  vec_t vt[22];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count output updates seen between edges.
  always @(negedge clk) if (bus.vld_out) upd_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic [11:0] pid, input logic [7:0] ss, input logic [11:0] pot,
                        input logic en, input logic pwr, input logic vld);
    bus.PID_cntrl = pid;
    bus.ss_tmr    = ss;
    bus.steer_pot = pot;
    bus.en_steer  = en;
    bus.pwr_up    = pwr;
    bus.vld_in    = vld;
  endtask

  task automatic do_reset();
    set_in(12'h0, 8'h0, 12'h800, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    upd_cnt = 0;
  endtask

  task automatic stream(input logic [11:0] pid, input logic [7:0] ss, input logic [11:0] pot,
                        input logic en, input logic pwr, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      set_in(pid, ss, pot, en, pwr, 1'b1);
    end
    @(negedge clk);
    bus.vld_in = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    upd_cnt = 0;
    rst_n   = 1'b0;
    set_in(12'h0, 8'h0, 12'h800, 1'b0, 1'b0, 1'b0);
    #1;
    chk("reset_lft", int'(bus.lft_spd), 0);
    chk("reset_rght", int'(bus.rght_spd), 0);
    chk("reset_vld", int'(bus.vld_out), 0);
    chk("reset_tf", int'(bus.too_fast), 0);

    vt[0]  = '{12'h100, 8'hFF, 12'h800, 1'b0, 1'b1, 1,  64,    64,    0};
    vt[1]  = '{12'h100, 8'hFF, 12'h800, 1'b0, 1'b1, 18, 1152,  1152,  0};
    vt[2]  = '{12'h100, 8'hFF, 12'h800, 1'b0, 1'b1, 19, 1215,  1215,  0};
    vt[3]  = '{12'h100, 8'hFF, 12'h800, 1'b0, 1'b1, 25, 1215,  1215,  0};
    vt[4]  = '{12'h020, 8'hFF, 12'h800, 1'b0, 1'b1, 7,  448,   448,   0};
    vt[5]  = '{12'h020, 8'hFF, 12'h800, 1'b0, 1'b1, 8,  496,   496,   0};
    vt[6]  = '{12'hFE0, 8'hFF, 12'h800, 1'b0, 1'b1, 20, -512,  -512,  0};
    vt[7]  = '{12'h000, 8'hFF, 12'hF00, 1'b1, 1'b1, 30, 1248,  -1248, 0};
    vt[8]  = '{12'h000, 8'hFF, 12'hF00, 1'b0, 1'b1, 30, 0,     0,     0};
    vt[9]  = '{12'h000, 8'hFF, 12'h000, 1'b1, 1'b1, 30, -1248, 1248,  0};
    vt[10] = '{12'h100, 8'hFF, 12'hE00, 1'b1, 1'b1, 30, 1503,  -528,  0};
    vt[11] = '{12'h7FF, 8'hFF, 12'h800, 1'b0, 1'b1, 28, 1792,  1792,  0};
    vt[12] = '{12'h7FF, 8'hFF, 12'h800, 1'b0, 1'b1, 29, 1856,  1856,  0};
    vt[13] = '{12'h7FF, 8'hFF, 12'h800, 1'b0, 1'b1, 31, 1984,  1984,  0};
    vt[14] = '{12'h7FF, 8'hFF, 12'h800, 1'b0, 1'b1, 32, 2047,  2047,  1};
    vt[15] = '{12'h800, 8'hFF, 12'h800, 1'b0, 1'b1, 33, -2048, -2048, 0};
    vt[16] = '{12'h03D, 8'hFF, 12'h800, 1'b0, 1'b1, 20, 960,   960,   0};
    vt[17] = '{12'h03E, 8'hFF, 12'h800, 1'b0, 1'b1, 20, 1021,  1021,  0};
    vt[18] = '{12'hFC3, 8'hFF, 12'h800, 1'b0, 1'b1, 20, -1021, -1021, 0};
    vt[19] = '{12'hFC4, 8'hFF, 12'h800, 1'b0, 1'b1, 20, -960,  -960,  0};
    vt[20] = '{12'h7FF, 8'h80, 12'h800, 1'b0, 1'b1, 40, 1983,  1983,  1};
    vt[21] = '{12'h7FF, 8'hFF, 12'h800, 1'b0, 1'b0, 5,  0,     0,     0};

    for (int i = 0; i < 22; i++) begin
      do_reset();
      stream(vt[i].pid, vt[i].ss, vt[i].pot, vt[i].en, vt[i].pwr, vt[i].n);
      chk($sformatf("vec%0d_lft", i), int'(bus.lft_spd), vt[i].el);
      chk($sformatf("vec%0d_rght", i), int'(bus.rght_spd), vt[i].er);
      chk($sformatf("vec%0d_tf", i), int'(bus.too_fast), vt[i].tf);
      chk($sformatf("vec%0d_updates", i), upd_cnt, vt[i].n);
    end

    do_reset();
    @(negedge clk);
    set_in(12'h100, 8'hFF, 12'h800, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    bus.vld_in = 1'b0;
    chk("lat_c1", int'(bus.vld_out), 0);
    @(negedge clk);
    chk("lat_c2", int'(bus.vld_out), 0);
    @(negedge clk);
    chk("lat_c3", int'(bus.vld_out), 1);
    chk("lat_c3_lft", int'(bus.lft_spd), 64);
    @(negedge clk);
    chk("lat_c4", int'(bus.vld_out), 0);

    do_reset();
    stream(12'h7FF, 8'hFF, 12'h800, 1'b0, 1'b1, 32);
    stream(12'h7FF, 8'hFF, 12'h800, 1'b0, 1'b0, 1);
    chk("tf_hold_lft", int'(bus.lft_spd), 1983);
    chk("tf_hold", int'(bus.too_fast), 1);
    stream(12'h7FF, 8'hFF, 12'h800, 1'b0, 1'b0, 2);
    chk("tf_hold2", int'(bus.too_fast), 1);
    stream(12'h7FF, 8'hFF, 12'h800, 1'b0, 1'b0, 1);
    chk("tf_clr_lft", int'(bus.lft_spd), 1791);
    chk("tf_clr", int'(bus.too_fast), 0);

    do_reset();
    stream(12'h100, 8'hFF, 12'h800, 1'b0, 1'b1, 25);
    stream(12'h100, 8'hFF, 12'h800, 1'b0, 1'b0, 18);
    chk("pd_lft_18", int'(bus.lft_spd), 63);
    chk("pd_rght_18", int'(bus.rght_spd), 63);
    stream(12'h100, 8'hFF, 12'h800, 1'b0, 1'b0, 1);
    chk("pd_lft_19", int'(bus.lft_spd), 0);
    chk("pd_rght_19", int'(bus.rght_spd), 0);

    do_reset();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      set_in(12'h7FF, 8'hFF, 12'h800, 1'b0, 1'b1, 1'b1);
    end
    @(posedge clk);
    #2;
    chk("arst_pre_vld", int'(bus.vld_out), 1);
    chk("arst_pre_tf", int'(bus.too_fast), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_lft", int'(bus.lft_spd), 0);
    chk("arst_rght", int'(bus.rght_spd), 0);
    chk("arst_vld", int'(bus.vld_out), 0);
    chk("arst_tf", int'(bus.too_fast), 0);
    @(negedge clk);
    bus.vld_in = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    upd_cnt = 0;
    repeat (6) @(negedge clk);
    chk("arst_no_stale", upd_cnt, 0);
    stream(12'h7FF, 8'hFF, 12'h800, 1'b0, 1'b1, 1);
    chk("arst_first_upd", upd_cnt, 1);
    chk("arst_first_lft", int'(bus.lft_spd), 64);

    do_reset();
    begin
      int k;
      int prev;
      int exp;
      k = 0;
      prev = 0;
      for (int c = 0; c < 70; c++) begin
        @(negedge clk);
        if (bus.vld_out) begin
          k++;
          exp = (64 * k > 1215) ? 1215 : 64 * k;
          chk($sformatf("bub_upd%0d_lft", k), int'(bus.lft_spd), exp);
          chk($sformatf("bub_upd%0d_rght", k), int'(bus.rght_spd), exp);
        end else begin
          chk($sformatf("bub_hold_c%0d", c), int'(bus.lft_spd), prev);
        end
        prev = int'(bus.lft_spd);
        set_in(12'h100, 8'hFF, 12'h800, 1'b0, 1'b1, (c % 3 == 0) && (c < 66));
      end
      chk("bub_count", k, 22);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/segway_math_pipe.md
SEGWAY_MATH_PIPE -- requirements
Module: segway_math_pipe

Interface
REQ-001 Parameter W, default 12: signed width of PID_cntrl, lft_spd and rght_spd; unsigned width of steer_pot.
REQ-002 Parameter SS_W, default 8: width of ss_tmr.
REQ-003 Parameters MIN_DUTY=960, LOW_BAND=60, GAIN_SHIFT=4: deadzone shaping constants.
REQ-004 Parameter SLEW, default 64: maximum output change per update.
REQ-005 Parameters FAST_THR=1792, FAST_CNT=4: too_fast threshold and persistence count.
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 vld_in  in  1  input sample valid, one cycle per sample.
REQ-009 PID_cntrl  in  W  signed PID output.
REQ-010 ss_tmr  in  SS_W  unsigned soft-start scale.
REQ-011 steer_pot  in  W  unsigned steering potentiometer.
REQ-012 en_steer  in  1  steering enable.
REQ-013 pwr_up  in  1  motor power enable.
REQ-014 vld_out  out  1  output update strobe.
REQ-015 lft_spd / rght_spd  out  W each  signed speed commands.
REQ-016 too_fast  out  1  persistent overspeed flag.

Function
REQ-017 The block SHALL be a 3-stage pipeline; each stage loads only when its incoming valid is high, otherwise it holds. vld_out SHALL pulse exactly 3 cycles after each vld_in. Back-to-back samples SHALL be accepted every cycle.
REQ-018 Stage 1 SHALL compute PID_ss as (PID_cntrl × zero-extended ss_tmr) arithmetically shifted right by SS_W, truncated to W bits.
REQ-019 Stage 1 SHALL clamp steer_pot to the range [2^(W-3), 7·2^(W-3)], subtract 2^(W-1)-1 (signed), then scale it by (x>>>4)+(x>>>3).
REQ-020 Torque SHALL be W+1 bits signed.
- en_steer=1: lft = PID_ss + steer; rght = PID_ss − steer.
- en_steer=0: both equal sign-extended PID_ss.
- pwr_up and all torques SHALL be registered together.
REQ-021 Stage 2 SHALL shape each torque t:
- |t| > LOW_BAND: t ± MIN_DUTY, sign following t.
- Otherwise: t << GAIN_SHIFT.
- The result SHALL saturate to W-bit signed, i.e. [−2^(W-1), 2^(W-1)−1].
- A registered pwr_up=0 SHALL force the target to 0.
REQ-022 Stage 3 SHALL apply a per-side slew limit: new output = target clamped to [out−SLEW, out+SLEW]. Clamp arithmetic SHALL be done at W+1 bits, then saturated to W bits, so it never wraps.
REQ-023 pwr_up=0 SHALL NOT zero the outputs directly; outputs SHALL ramp toward 0 at SLEW per update.
REQ-024 too_fast counter (0..FAST_CNT, saturating) SHALL update only on output updates.
- Either new output > FAST_THR (signed): counter increments.
- Otherwise: counter clears.
- too_fast = (counter == FAST_CNT), registered and aligned with vld_out.
REQ-025 Negative speeds SHALL never assert too_fast.

Reset
REQ-026 When rst_n is low, all pipeline registers, outputs, vld_out, the counter and too_fast SHALL be 0 immediately, independent of clk.
REQ-027 Reset asserted mid-stream SHALL discard every in-flight sample; the first vld_out after release SHALL correspond to a sample presented after release.

Verification
REQ-028 Latency/ramp: PID_cntrl=0x100, ss_tmr=0xFF, en_steer=0, pwr_up=1, vld_in every cycle.
- Target = 1215 on both sides.
- Outputs step 64, 128, …, 1152, then 1215 on update 19, then hold.
- First vld_out appears 3 cycles after the first vld_in.
REQ-029 Deadzone: PID_cntrl=0x020, ss_tmr=0xFF.
- PID_ss = 31, target = 496.
- Output reaches 496 after 8 updates.
- Negated input (0xFE0) gives PID_ss = −32 and target −512.
REQ-030 Steering: PID_cntrl=0, steer_pot=0xF00, en_steer=1.
- Steer clamps to 0xE00, giving steer term 288.
- Settled output: lft = 1248, rght = −1248.
- Same stimulus with en_steer=0: both settle at 0.
REQ-031 Overspeed: PID_cntrl=0x7FF, ss_tmr=0xFF.
- Target saturates to 2047.
- Output first exceeds 1792 on update 29 (1856).
- too_fast asserts on update 32.
- One valid sample with pwr_up=0 then clears too_fast on that update only if the ramped output is ≤ 1792; otherwise too_fast stays asserted.
REQ-032 Power-down/reset:
- Settled at 1215, drop pwr_up: outputs fall by 64 per update to 0.
- Pulse rst_n low mid-ramp: outputs, vld_out and too_fast are 0 asynchronously, and no stale vld_out follows release.
REQ-033 Bubbles: vld_in asserted only every 3rd cycle.
- Outputs change only on vld_out cycles.
- Results match the continuous-valid run update-for-update.
